// File: rtl/jtag_types_pkg.sv
// Shared JTAG instruction definitions used by the IR and the instruction decoder.
package jtag_types_pkg;

  localparam int unsigned IR_WIDTH = 5;

  typedef logic [IR_WIDTH-1:0] instruction_t;

  typedef enum logic [IR_WIDTH-1:0] {
    EXTEST         = 5'b00000,
    IDCODE         = 5'b00001,
    SAMPLE_PRELOAD = 5'b00010,
    AHB            = 5'b01000,
    BYPASS         = 5'b11111
  } opcode_e;

  // LSBs 2'b01 are mandatory for the capture value of any IR.
  localparam instruction_t CAPTURE_PATTERN_DEFAULT = 5'b00001;

  // True when the opcode is one the decoder implements.
  function automatic logic is_legal_opcode(input instruction_t op);
    logic legal;
    legal = 1'b0;
    case (op)
      EXTEST, IDCODE, SAMPLE_PRELOAD, AHB, BYPASS: legal = 1'b1;
      default:                                     legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/jtag_instruction_register.sv
// JTAG instruction register: capture/shift stage plus held, legalised instruction.
module jtag_instruction_register
  import jtag_types_pkg::*;
#(
  parameter int unsigned  IR_WIDTH        = jtag_types_pkg::IR_WIDTH,
  parameter instruction_t CAPTURE_PATTERN = CAPTURE_PATTERN_DEFAULT
) (
  input  logic         TCK,
  input  logic         TRST,
  input  logic         TDI,
  input  logic         tlr,
  input  logic         capture_ir,
  input  logic         shift_ir,
  input  logic         update_ir,
  output instruction_t parallel_out,
  output logic         ir_tdo,
  output logic         instr_updated,
  output logic         illegal_opcode
);

  logic [IR_WIDTH-1:0] shift_q;
  instruction_t        hold_q;
  logic                instr_updated_q;
  logic                illegal_q;

  // Shift stage: capture has priority over shift; test-logic-reset overrides both.
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      shift_q <= CAPTURE_PATTERN;
    end else if (tlr) begin
      shift_q <= CAPTURE_PATTERN;
    end else if (capture_ir) begin
      shift_q <= CAPTURE_PATTERN;
    end else if (shift_ir) begin
      shift_q <= {TDI, shift_q[IR_WIDTH-1:1]};
    end
  end

  // Held instruction: only Update-IR, test-logic-reset or TRST may change it.
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      hold_q          <= IDCODE;
      instr_updated_q <= 1'b0;
      illegal_q       <= 1'b0;
    end else if (tlr) begin
      hold_q          <= IDCODE;
      instr_updated_q <= 1'b0;
      illegal_q       <= 1'b0;
    end else if (update_ir) begin
      instr_updated_q <= 1'b1;
      if (is_legal_opcode(instruction_t'(shift_q))) begin
        hold_q    <= instruction_t'(shift_q);
        illegal_q <= 1'b0;
      end else begin
        hold_q    <= BYPASS;
        illegal_q <= 1'b1;
      end
    end else begin
      instr_updated_q <= 1'b0;
    end
  end

  assign parallel_out   = hold_q;
  assign ir_tdo         = shift_q[0];
  assign instr_updated  = instr_updated_q;
  assign illegal_opcode = illegal_q;

endmodule

// File: tb/tb_jtag_instruction_register.sv
// Directed, table-driven bench for the JTAG instruction register.
module tb_jtag_instruction_register;
  import jtag_types_pkg::*;

  logic         TCK = 1'b0;
  logic         TRST;
  logic         TDI;
  logic         tlr;
  logic         capture_ir;
  logic         shift_ir;
  logic         update_ir;
  instruction_t parallel_out;
  logic         ir_tdo;
  logic         instr_updated;
  logic         illegal_opcode;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic         t_tlr;
    logic         t_cap;
    logic         t_sh;
    logic         t_upd;
    logic         t_tdi;
    instruction_t e_po;
    logic         e_tdo;
    logic         e_upd;
    logic         e_ill;
  } vec_t;

  vec_t vecs[$];

  jtag_instruction_register dut (
    .TCK            (TCK),
    .TRST           (TRST),
    .TDI            (TDI),
    .tlr            (tlr),
    .capture_ir     (capture_ir),
    .shift_ir       (shift_ir),
    .update_ir      (update_ir),
    .parallel_out   (parallel_out),
    .ir_tdo         (ir_tdo),
    .instr_updated  (instr_updated),
    .illegal_opcode (illegal_opcode)
  );

  always #5 TCK = ~TCK;

  function automatic vec_t v(input logic t, input logic c, input logic s, input logic u,
                             input logic d, input logic [4:0] po, input logic tdo,
                             input logic upd, input logic ill);
    vec_t r;
    r.t_tlr = t; r.t_cap = c; r.t_sh = s; r.t_upd = u; r.t_tdi = d;
    r.e_po = po; r.e_tdo = tdo; r.e_upd = upd; r.e_ill = ill;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b required=%b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input logic [4:0] po, input logic tdo,
                         input logic upd, input logic ill);
    chk({nm, ".parallel_out"},   parallel_out,          po);
    chk({nm, ".ir_tdo"},         5'(ir_tdo),            5'(tdo));
    chk({nm, ".instr_updated"},  5'(instr_updated),     5'(upd));
    chk({nm, ".illegal_opcode"}, 5'(illegal_opcode),    5'(ill));
  endtask

  // Drive strobes between edges, then sample just after the rising edge.
  task automatic step(input logic t, input logic c, input logic s, input logic u, input logic d);
    @(negedge TCK);
    tlr = t; capture_ir = c; shift_ir = s; update_ir = u; TDI = d;
    @(posedge TCK);
    #1;
  endtask

  task automatic shift5(input logic [4:0] val);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, val[i]);
  endtask

  initial begin
    TRST = 1'b1; TDI = 1'b0; tlr = 1'b0; capture_ir = 1'b0; shift_ir = 1'b0; update_ir = 1'b0;
    repeat (2) @(posedge TCK);
    @(negedge TCK);
    TRST = 1'b0;
    #1;
    chk_all("reset", 5'b00001, 1'b1, 1'b0, 1'b0);

    // idle
    vecs.push_back(v(0,0,0,0,0, 5'b00001, 1, 0, 0));
    // AHB = 01000, LSB first 0,0,0,1,0
    vecs.push_back(v(0,1,0,0,0, 5'b00001, 1, 0, 0));
    vecs.push_back(v(0,0,1,0,0, 5'b00001, 0, 0, 0));
    vecs.push_back(v(0,0,1,0,0, 5'b00001, 0, 0, 0));
    vecs.push_back(v(0,0,1,0,0, 5'b00001, 0, 0, 0));
    vecs.push_back(v(0,0,1,0,1, 5'b00001, 0, 0, 0));
    vecs.push_back(v(0,0,1,0,0, 5'b00001, 0, 0, 0));
    vecs.push_back(v(0,0,0,1,0, 5'b01000, 0, 1, 0));
    vecs.push_back(v(0,0,0,0,0, 5'b01000, 0, 0, 0));
    // illegal 00110: 0,1,1,0,0
    vecs.push_back(v(0,1,0,0,0, 5'b01000, 1, 0, 0));
    vecs.push_back(v(0,0,1,0,0, 5'b01000, 0, 0, 0));
    vecs.push_back(v(0,0,1,0,1, 5'b01000, 0, 0, 0));
    vecs.push_back(v(0,0,1,0,1, 5'b01000, 0, 0, 0));
    vecs.push_back(v(0,0,1,0,0, 5'b01000, 0, 0, 0));
    vecs.push_back(v(0,0,1,0,0, 5'b01000, 0, 0, 0));
    vecs.push_back(v(0,0,0,1,0, 5'b11111, 0, 1, 1));
    vecs.push_back(v(0,0,0,0,0, 5'b11111, 0, 0, 1));
    // SAMPLE_PRELOAD 00010: 0,1,0,0,0
    vecs.push_back(v(0,1,0,0,0, 5'b11111, 1, 0, 1));
    vecs.push_back(v(0,0,1,0,0, 5'b11111, 0, 0, 1));
    vecs.push_back(v(0,0,1,0,1, 5'b11111, 0, 0, 1));
    vecs.push_back(v(0,0,1,0,0, 5'b11111, 0, 0, 1));
    vecs.push_back(v(0,0,1,0,0, 5'b11111, 0, 0, 1));
    vecs.push_back(v(0,0,1,0,0, 5'b11111, 0, 0, 1));
    vecs.push_back(v(0,0,0,1,0, 5'b00010, 0, 1, 0));
    vecs.push_back(v(0,0,0,0,0, 5'b00010, 0, 0, 0));
    // reload AHB
    vecs.push_back(v(0,1,0,0,0, 5'b00010, 1, 0, 0));
    vecs.push_back(v(0,0,1,0,0, 5'b00010, 0, 0, 0));
    vecs.push_back(v(0,0,1,0,0, 5'b00010, 0, 0, 0));
    vecs.push_back(v(0,0,1,0,0, 5'b00010, 0, 0, 0));
    vecs.push_back(v(0,0,1,0,1, 5'b00010, 0, 0, 0));
    vecs.push_back(v(0,0,1,0,0, 5'b00010, 0, 0, 0));
    vecs.push_back(v(0,0,0,1,0, 5'b01000, 0, 1, 0));
    // capture + shifts without update: held instruction must not move
    vecs.push_back(v(0,1,0,0,0, 5'b01000, 1, 0, 0));
    vecs.push_back(v(0,0,1,0,1, 5'b01000, 0, 0, 0));
    vecs.push_back(v(0,0,1,0,0, 5'b01000, 0, 0, 0));
    vecs.push_back(v(0,0,1,0,1, 5'b01000, 0, 0, 0));
    vecs.push_back(v(0,0,0,0,0, 5'b01000, 0, 0, 0));
    vecs.push_back(v(0,0,1,0,0, 5'b01000, 0, 0, 0));
    vecs.push_back(v(0,0,1,0,0, 5'b01000, 1, 0, 0));
    vecs.push_back(v(0,0,1,0,0, 5'b01000, 0, 0, 0));
    vecs.push_back(v(0,0,0,0,0, 5'b01000, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].t_tlr, vecs[i].t_cap, vecs[i].t_sh, vecs[i].t_upd, vecs[i].t_tdi);
      chk_all($sformatf("vec%0d", i), vecs[i].e_po, vecs[i].e_tdo, vecs[i].e_upd, vecs[i].e_ill);
    end

    // asynchronous TRST after two of five shift bits
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 1);
    chk_all("pre_trst", 5'b01000, 1'b0, 1'b0, 1'b0);
    @(negedge TCK);
    shift_ir = 1'b0;
    #1 TRST = 1'b1;
    #1;
    chk_all("trst_async", 5'b00001, 1'b1, 1'b0, 1'b0);
    #1 TRST = 1'b0;
    step(0, 0, 0, 0, 0);
    chk_all("trst_after", 5'b00001, 1'b1, 1'b0, 1'b0);
    shift5(5'b01000);
    step(0, 0, 0, 1, 0);
    chk_all("post_trst_upd", 5'b01000, 1'b0, 1'b1, 1'b0);
    step(0, 0, 0, 0, 0);
    chk_all("post_trst_idle", 5'b01000, 1'b0, 1'b0, 1'b0);

    // illegal flag set, then tlr together with update of a legal opcode
    shift5(5'b00110);
    step(0, 0, 0, 1, 0);
    chk_all("ill_before_tlr", 5'b11111, 1'b0, 1'b1, 1'b1);
    shift5(5'b00010);
    step(1, 0, 0, 1, 0);
    chk_all("tlr_upd", 5'b00001, 1'b1, 1'b0, 1'b0);
    step(1, 0, 1, 0, 0);
    chk_all("tlr_hold", 5'b00001, 1'b1, 1'b0, 1'b0);
    step(0, 0, 0, 0, 0);
    chk_all("tlr_release", 5'b00001, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jtag_instruction_register.md
Name: jtag_instruction_register

Overview:
- Instruction register (IR) of the JTAG TAP. Captures a fixed pattern, serially shifts in an opcode from TDI while shifting the old contents out, and latches the opcode into a held register on Update-IR.
- Drives parallel_out into the instruction decoder, which turns it into data-register selects.
- Sequenced by the existing TAP controller's state strobes.
- Legalises unknown opcodes to BYPASS before they reach the decoder.

Parameters:
- IR_WIDTH, 5, instruction length in bits; must equal the width of instruction_t.
- CAPTURE_PATTERN, 5'b00001, value loaded into the shift stage on Capture-IR. LSBs must be 2'b01 per 1149.1.

Ports:
- TCK  input  1  test clock; all state updates on rising edge.
- TRST  input  1  asynchronous, active-high reset.
- TDI  input  1  serial data in.
- tlr  input  1  TAP in Test-Logic-Reset.
- capture_ir  input  1  TAP in Capture-IR.
- shift_ir  input  1  TAP in Shift-IR.
- update_ir  input  1  TAP in Update-IR.
- parallel_out  output  instruction_t  held instruction to the decoder.
- ir_tdo  output  1  serial output of the IR shift stage, to the TDO mux.
- instr_updated  output  1  one-cycle pulse: parallel_out changed via Update-IR.
- illegal_opcode  output  1  sticky flag: last update carried an unknown opcode.

Behaviour:
- Storage: shift_q[IR_WIDTH-1:0], hold_q (instruction_t), instr_updated_q, illegal_q.
- Reset (TRST high, asynchronous): shift_q = CAPTURE_PATTERN, hold_q = IDCODE, instr_updated = 0, illegal_opcode = 0.
- Priority each TCK rising edge: tlr > capture_ir > shift_ir. update_ir is evaluated independently but is overridden by tlr.
- tlr: same values as reset, synchronously; stays in effect every cycle tlr is high.
- capture_ir: shift_q <= CAPTURE_PATTERN; hold_q unchanged.
- shift_ir: shift_q <= {TDI, shift_q[IR_WIDTH-1:1]}. LSB leaves first; TDI enters the MSB.
- ir_tdo = shift_q[0], taken straight from the register with no added combinational path.
  - The first bit shifted out is CAPTURE_PATTERN[0] = 1, then 0.
  - After IR_WIDTH shifts, the first TDI bit presented is in shift_q[0].
- update_ir:
  - shift_q decoded against the legal opcode set in the package.
  - Legal: hold_q <= shift_q, illegal_q <= 0.
  - Illegal: hold_q <= BYPASS (all ones), illegal_q <= 1.
  - instr_updated pulses high for exactly one cycle after the update edge, whether or not the opcode was legal.
- No strobes asserted: all state holds.
- parallel_out changes only on update_ir, tlr or TRST. It never changes during capture or shift, so decoder selects stay stable while the IR shifts.
- Latency:
  - Update-IR edge to new parallel_out: 1 TCK edge.
  - Shift edge to new ir_tdo: 1 edge.
- Multiple strobes high at once:
  - Treated per the priority above; not expected from a legal TAP.
  - The assertion bench flags capture_ir & shift_ir, and update_ir & (capture_ir | shift_ir).
- Reset mid-shift: partial data discarded, IDCODE restored. No update pulse.

Decomposition:
- jtag_types_pkg holds:
  - IR_WIDTH constant and instruction_t.
  - Opcode enum: EXTEST 5'b00000, IDCODE 5'b00001, SAMPLE_PRELOAD 5'b00010, AHB 5'b01000, BYPASS 5'b11111.
  - CAPTURE_PATTERN default.
  - Legality check function is_legal_opcode().
- Single module, no sub-module. Decoder legality lives in the package function so the instruction decoder and this block agree on the opcode set.

Test Plan:
- Assert TRST, release; no strobes -> parallel_out=5'b00001 (IDCODE), ir_tdo=1, instr_updated=0, illegal_opcode=0.
- capture_ir for 1 cycle, shift_ir 5 cycles with TDI=0,0,0,1,0 (LSB first), update_ir 1 cycle:
  - ir_tdo sequence 1,0,0,0,0;
  - parallel_out=5'b01000 (AHB) one edge after update;
  - instr_updated high for exactly 1 cycle.
- Shift in 5'b00110 (illegal), update -> parallel_out=5'b11111, illegal_opcode=1. Then shift/update 5'b00010 -> parallel_out=5'b00010, illegal_opcode=0.
- Load AHB, then capture plus 3 shifts without update -> parallel_out stays 5'b01000 throughout; ir_tdo follows capture then TDI history.
- Mid-shift (after 2 of 5 bits), pulse TRST asynchronously between edges:
  - outputs go to reset values immediately;
  - no instr_updated pulse;
  - a full 5-bit shift/update afterwards works normally.
- tlr and update_ir high together with shift_q=5'b00010 -> parallel_out=IDCODE, instr_updated=0.
